// File: rtl/l1_flatten.sv
// l1_flatten: copies both Layer-1 pooled maps into Layer-2 memory as one interleaved, flattened vector.
// Bus sequence per pixel: read K0, read K1, write K0 word, write K1 word.
module l1_flatten #(
    parameter int N_PIX = 1024,
    parameter int AW = 12,
    parameter int DW = 20,
    parameter logic [2:0] SEL_K0 = 3'b011,
    parameter logic [2:0] SEL_K1 = 3'b100,
    parameter logic [2:0] SEL_L2 = 3'b101
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);
    localparam int IW = $clog2(N_PIX);
    typedef enum logic [2:0] {IDLE, RD_K0, RD_K1, WR_K0, WR_K1, FIN} state_t;
    state_t state;
    logic [IW-1:0] i;
    // Outputs are loaded on the edge entering a state; cdata_wr doubles as the hold register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            crd <= 1'b0;
            cwr <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    crd <= 1'b0;
                    cwr <= 1'b0;
                    csel <= 3'b000;
                    if (start) begin
                        state <= RD_K0;
                        i <= '0;
                        busy <= 1'b1;
                        crd <= 1'b1;
                        csel <= SEL_K0;
                        caddr_rd <= '0;
                    end
                end
                RD_K0: begin
                    state <= RD_K1;
                    csel <= SEL_K1;
                end
                RD_K1: begin
                    state <= WR_K0;
                    crd <= 1'b0;
                    cwr <= 1'b1;
                    csel <= SEL_L2;
                    caddr_wr <= AW'({i, 1'b0});
                    cdata_wr <= cdata_rd;
                end
                WR_K0: begin
                    state <= WR_K1;
                    caddr_wr <= AW'({i, 1'b1});
                    cdata_wr <= cdata_rd;
                end
                WR_K1: begin
                    cwr <= 1'b0;
                    if (i == IW'(N_PIX - 1)) begin
                        state <= FIN;
                        done <= 1'b1;
                        busy <= 1'b0;
                        csel <= 3'b000;
                    end else begin
                        state <= RD_K0;
                        i <= i + 1'b1;
                        crd <= 1'b1;
                        csel <= SEL_K0;
                        caddr_rd <= AW'(i + 1'b1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_flatten.sv
// tb_l1_flatten: random-data flatten passes checked against an interleave model of Layer-2 memory.
module tb_l1_flatten;
    localparam int N = 1024;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, crd, cwr;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_rd, cdata_wr;
    logic [2:0] csel;
    logic [19:0] rd_q = '0;
    logic [19:0] k0 [N];
    logic [19:0] k1 [N];
    logic [19:0] l2 [2*N];
    int wgen [2*N];
    int gen = 0;
    int nrd = 0, nwr = 0, overlap = 0, badsel = 0;
    int errors = 0, checks = 0;

    l1_flatten dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;
    assign cdata_rd = rd_q;

    // Synchronous memory model: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (crd) begin
            nrd <= nrd + 1;
            rd_q <= (csel == 3'b011) ? k0[caddr_rd[9:0]] : (csel == 3'b100) ? k1[caddr_rd[9:0]] : 20'hDEAD0;
        end
        if (cwr) begin
            nwr <= nwr + 1;
            if (csel == 3'b101 && caddr_wr < 12'd2048) begin
                l2[caddr_wr[10:0]] <= cdata_wr;
                wgen[caddr_wr[10:0]] <= gen;
            end else badsel <= badsel + 1;
        end
        if (crd && cwr) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input bit rnd);
        for (int j = 0; j < N; j++) begin
            k0[j] = rnd ? 20'($urandom) : 20'(j);
            k1[j] = rnd ? 20'($urandom) : (20'hF0000 | 20'(j));
        end
        if (rnd) begin
            k0[0] = 20'h80000;
            k1[0] = 20'h7FFFF;
            k0[N-1] = 20'hFFFFF;
        end
    endtask

    task automatic run_pass(input bit spur, input int abort_at);
        int ndone, nbusy, done_at, w0, w;
        int bad;
        logic [19:0] e;
        gen++;
        ndone = 0;
        nbusy = 0;
        done_at = 0;
        @(negedge clk);
        w0 = nwr;
        start = 1'b1;
        for (int cyc = 1; cyc <= 4110; cyc++) begin
            @(negedge clk);
            start = spur && (cyc == 99 || cyc == 4097);
            if (done) begin ndone++; done_at = cyc; end
            if (busy) nbusy++;
            if (cyc == 21) chk("px5_rdk0", {crd, cwr, csel, caddr_rd}, {1'b1, 1'b0, 3'b011, 12'd5});
            if (cyc == 22) chk("px5_rdk1", {crd, cwr, csel, caddr_rd}, {1'b1, 1'b0, 3'b100, 12'd5});
            if (cyc == 23) chk("px5_wrk0", {crd, cwr, csel, caddr_wr}, {1'b0, 1'b1, 3'b101, 12'd10});
            if (cyc == 24) chk("px5_wrk1", {crd, cwr, csel, caddr_wr}, {1'b0, 1'b1, 3'b101, 12'd11});
            if (cyc == 4096) chk("last_wr_addr", {cwr, caddr_wr}, {1'b1, 12'd2047});
            if (abort_at != 0 && cyc == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_outs", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
                @(negedge clk);
                reset = 1'b0;
                w = nwr;
                repeat (30) @(negedge clk);
                chk("abort_no_wr", nwr - w, 0);
                chk("abort_idle", {busy, done, crd, cwr}, 4'd0);
                return;
            end
        end
        chk("done_count", ndone, 1);
        chk("done_cycle", done_at, 4097);
        chk("busy_cycles", nbusy, 4096);
        chk("write_count", nwr - w0, 2 * N);
        chk("overlap", overlap, 0);
        chk("bad_write_sel", badsel, 0);
        bad = 0;
        for (int a = 0; a < 2 * N; a++) begin
            e = a[0] ? k1[a >> 1] : k0[a >> 1];
            if (wgen[a] != gen || l2[a] !== e) begin
                bad++;
                if (bad <= 4) chk("l2_word", {wgen[a] == gen, l2[a]}, {1'b1, e});
            end
        end
        chk("l2_bad_words", bad, 0);
    endtask

    initial begin
        for (int a = 0; a < 2 * N; a++) begin wgen[a] = 0; l2[a] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_outs", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
        chk("idle_rd", nrd, 0);
        chk("idle_wr", nwr, 0);
        fill(1'b0);
        run_pass(1'b0, 0);
        fill(1'b1);
        run_pass(1'b1, 0);
        chk("ext_l2_0", l2[0], 20'h80000);
        chk("ext_l2_1", l2[1], 20'h7FFFF);
        chk("ext_l2_2046", l2[2046], 20'hFFFFF);
        fill(1'b1);
        run_pass(1'b0, 2000);
        fill(1'b1);
        run_pass(1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
